fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the pipelined RV32I core; the

---
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight register writes over
// NUM_FWD_SRC post-ID stages and produces per-operand forward selects and stall.
module fwd_hazard_unit #(
    parameter int NUM_FWD_SRC  = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_FWD_SRC = 2,
    parameter int CNT_W        = 32,
    localparam int SEL_W       = $clog2(NUM_FWD_SRC + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_is_load_i,
    input  logic                  mem_stall_i,
    input  logic                  flush_i,
    output logic [SEL_W-1:0]      fwd_rs1_sel_o,
    output logic [SEL_W-1:0]      fwd_rs2_sel_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    logic [NUM_FWD_SRC-1:0]                 r_valid;
    logic [NUM_FWD_SRC-1:0]                 r_is_load;
    logic [NUM_FWD_SRC-1:0][REG_ADDR_W-1:0] r_rd;
    logic [CNT_W-1:0]                       r_cnt;

    logic [SEL_W:0]   w_rs1_res;
    logic [SEL_W:0]   w_rs2_res;
    logic             w_stall;
    logic             w_push;

    // Result is {hazard, sel}; only the youngest matching entry is considered.
    function automatic logic [SEL_W:0] lookup(
        input logic                                  used,
        input logic [REG_ADDR_W-1:0]                 rs,
        input logic [NUM_FWD_SRC-1:0]                valid,
        input logic [NUM_FWD_SRC-1:0]                is_load,
        input logic [NUM_FWD_SRC-1:0][REG_ADDR_W-1:0] rd
    );
        logic           hit;
        logic [SEL_W:0] res;
        hit = 1'b0;
        res = '0;
        for (int i = 0; i < NUM_FWD_SRC; i++) begin
            if (!hit && used && (rs != '0) && valid[i] && (rd[i] == rs)) begin
                hit = 1'b1;
                if (is_load[i] && ((i + 1) < LOAD_FWD_SRC))
                    res = {1'b1, {SEL_W{1'b0}}};
                else
                    res = {1'b0, SEL_W'(i + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rs1_res = lookup(id_rs1_used_i, id_rs1_i, r_valid, r_is_load, r_rd);
        w_rs2_res = lookup(id_rs2_used_i, id_rs2_i, r_valid, r_is_load, r_rd);
        w_stall   = id_valid_i && !flush_i && (w_rs1_res[SEL_W] || w_rs2_res[SEL_W]);
        w_push    = id_valid_i && !w_stall && !flush_i && id_regwrite_i && (id_rd_i != '0);
    end

    assign stall_o       = w_stall;
    assign fwd_rs1_sel_o = w_stall ? '0 : w_rs1_res[SEL_W-1:0];
    assign fwd_rs2_sel_o = w_stall ? '0 : w_rs2_res[SEL_W-1:0];
    assign stall_cnt_o   = r_cnt;

    // Entry 0 (source 1) takes the instruction leaving ID; a stall injects a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid[0]   <= 1'b0;
            r_is_load[0] <= 1'b0;
            r_rd[0]      <= '0;
        end else if (!mem_stall_i) begin
            r_valid[0]   <= w_push;
            r_is_load[0] <= id_is_load_i;
            r_rd[0]      <= id_rd_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < NUM_FWD_SRC; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[gi]   <= 1'b0;
                    r_is_load[gi] <= 1'b0;
                    r_rd[gi]      <= '0;
                end else if (!mem_stall_i) begin
                    r_valid[gi]   <= r_valid[gi-1];
                    r_is_load[gi] <= r_is_load[gi-1];
                    r_rd[gi]      <= r_rd[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_stall && !mem_stall_i && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed pipeline scenarios followed
// by random traffic, all compared against an instruction-history reference model.
module tb_fwd_hazard_unit;

    localparam int NSRC    = 2;
    localparam int AW      = 5;
    localparam int LDSRC   = 2;
    localparam int CW      = 4;
    localparam int SW      = $clog2(NSRC + 1);
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid_i, id_rs1_used_i, id_rs2_used_i;
    logic [AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic          id_regwrite_i, id_is_load_i, mem_stall_i, flush_i;
    logic [SW-1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
    logic          stall_o;
    logic [CW-1:0] stall_cnt_o;

    fwd_hazard_unit #(.NUM_FWD_SRC(NSRC), .REG_ADDR_W(AW), .LOAD_FWD_SRC(LDSRC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_is_load_i(id_is_load_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // History of what entered EX each cycle, newest first; bubbles have wr=0.
    typedef struct { bit wr; int rd; bit ld; } ent_t;
    ent_t hist[$];
    int   mcnt;
    int   exp_s1, exp_s2;
    bit   exp_st;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic void look(input bit used, input int rs, output bit haz, output int sel);
        haz = 0;
        sel = 0;
        if (!used || rs == 0) return;
        foreach (hist[k]) begin
            if (hist[k].wr && hist[k].rd == rs) begin
                if (hist[k].ld && (k + 1) < LDSRC) haz = 1;
                else sel = k + 1;
                return;
            end
        end
    endfunction

    function automatic void model_clear();
        ent_t b;
        b.wr = 0; b.rd = 0; b.ld = 0;
        hist = {};
        for (int i = 0; i < NSRC; i++) hist.push_back(b);
        mcnt = 0;
    endfunction

    // Apply inputs, let them settle mid-cycle, then compare against the model.
    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input bit ld, input bit ms, input bit fl,
                         input bit r);
        bit h1, h2;
        int s1, s2;
        id_valid_i = v;  id_rs1_i = AW'(rs1); id_rs1_used_i = u1;
        id_rs2_i = AW'(rs2); id_rs2_used_i = u2; id_rd_i = AW'(rd);
        id_regwrite_i = wr; id_is_load_i = ld; mem_stall_i = ms; flush_i = fl; rst = r;
        #3;
        look(u1, rs1, h1, s1);
        look(u2, rs2, h2, s2);
        exp_st = v && !fl && (h1 || h2);
        exp_s1 = exp_st ? 0 : s1;
        exp_s2 = exp_st ? 0 : s2;
        chk("sel1", int'(fwd_rs1_sel_o), exp_s1);
        chk("sel2", int'(fwd_rs2_sel_o), exp_s2);
        chk("stall", int'(stall_o), int'(exp_st));
        chk("cnt", int'(stall_cnt_o), mcnt);
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (!mem_stall_i) begin
            e.wr = id_valid_i && !exp_st && !flush_i && id_regwrite_i && (id_rd_i != 0);
            e.rd = int'(id_rd_i);
            e.ld = id_is_load_i;
            hist.push_front(e);
            void'(hist.pop_back());
            if (exp_st && mcnt != CNT_MAX) mcnt++;
        end
        #1;
    endtask

    initial begin
        //               v rs1 u1 rs2 u2 rd wr ld ms fl rst
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        id_rd_i = 0; id_regwrite_i = 0; id_is_load_i = 0; mem_stall_i = 0; flush_i = 0; rst = 1;
        @(posedge clk); model_clear(); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_stall", int'(stall_o), 0); chk("rst_cnt", int'(stall_cnt_o), 0);
        tick();

        // lw x5 ; add x6,x5,x1 : one bubble, then forward from source 2
        drive(1, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        chk("lu_stall", int'(stall_o), 1); chk("lu_sel1", int'(fwd_rs1_sel_o), 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        chk("lu_after_stall", int'(stall_o), 0); chk("lu_after_sel1", int'(fwd_rs1_sel_o), 2);
        chk("lu_after_cnt", int'(stall_cnt_o), 1);
        tick();

        // add x5 ; add x6,x5,x0
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("ex_sel1", int'(fwd_rs1_sel_o), 1); chk("ex_sel2", int'(fwd_rs2_sel_o), 0);
        tick();

        // add x5 ; nop ; sub x7,x5,x5
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 5, 1, 7, 1, 0, 0, 0, 0);
        chk("mem_sel1", int'(fwd_rs1_sel_o), 2); chk("mem_sel2", int'(fwd_rs2_sel_o), 2);
        tick();

        // add x5 (MEM) then addi x5 (EX): youngest wins
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 3, 1, 8, 1, 0, 0, 0, 0);
        chk("young_sel1", int'(fwd_rs1_sel_o), 1);
        tick();

        // addi x0 ; add x6,x0,x0 : x0 never tracked
        drive(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("x0_sel1", int'(fwd_rs1_sel_o), 0); chk("x0_stall", int'(stall_o), 0);
        tick();

        // load-use under a 3-cycle mem_stall, then flush while stalled
        drive(1, 1, 1, 2, 1, 9, 1, 1, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 0);
            chk("ms_stall", int'(stall_o), 1); chk("ms_cnt", int'(stall_cnt_o), 1);
            tick();
        end
        drive(1, 9, 1, 0, 0, 10, 1, 0, 0, 1, 0);
        chk("flush_stall", int'(stall_o), 0);
        tick();
        drive(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        chk("flush_noent", int'(fwd_rs1_sel_o), 0); chk("flush_old", int'(fwd_rs2_sel_o), 2);
        tick();

        // reset in the middle of a load-use stall
        drive(1, 1, 1, 2, 1, 12, 1, 1, 0, 0, 0); tick();
        drive(1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 1);
        chk("rstmid_stall", int'(stall_o), 1);
        tick();
        drive(1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0);
        chk("rstmid_after", int'(stall_o), 0); chk("rstmid_cnt", int'(stall_cnt_o), 0);
        tick();

        // random traffic; small register range keeps matches frequent and drives
        // the narrow counter into saturation
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(9, 0) != 0, int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
                  int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
                  $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 4, $urandom_range(9, 0) == 0,
                  $urandom_range(19, 0) == 0, n > 150 && $urandom_range(99, 0) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
